// File: rtl/aes_job_arbiter_if.sv
// Handshake bundle between the AES job arbiter, its two requesters, the round
// sequencer/core and the response consumer.
interface aes_job_arbiter_if;
    logic         req0;
    logic         req1;
    logic [127:0] pt0;
    logic [127:0] pt1;
    logic [127:0] key0;
    logic [127:0] key1;
    logic         gnt0;
    logic         gnt1;
    logic         core_start;
    logic [127:0] core_pt;
    logic [127:0] core_key;
    logic         core_done;
    logic [127:0] core_ct;
    logic         rsp_valid;
    logic         rsp_id;
    logic [127:0] rsp_ct;
    logic         rsp_err;
    logic         rsp_ready;
    logic         busy;

    modport slave (
        input  req0, req1, pt0, pt1, key0, key1, core_done, core_ct, rsp_ready,
        output gnt0, gnt1, core_start, core_pt, core_key,
               rsp_valid, rsp_id, rsp_ct, rsp_err, busy
    );

    modport master (
        output req0, req1, pt0, pt1, key0, key1, core_done, core_ct, rsp_ready,
        input  gnt0, gnt1, core_start, core_pt, core_key,
               rsp_valid, rsp_id, rsp_ct, rsp_err, busy
    );
endinterface

// File: rtl/aes_job_arbiter.sv
// Two-requester round-robin arbiter feeding one AES core, with a held response.
// Optional RUN-cycle watchdog enabled by defining AES_ARB_TIMEOUT_EN.
module aes_job_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input logic              clk,
    input logic              rstn,
    aes_job_arbiter_if.slave arb_if
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    if (TIMEOUT_CYC < 12 || TIMEOUT_CYC > 255) begin : gBadTimeout
        $error("TIMEOUT_CYC must lie in 12..255");
    end

    logic [1:0]   state_q, state_d;
    logic         rr_q, rr_d;
    logic         jobId_q, jobId_d;
    logic [127:0] corePt_q, corePt_d;
    logic [127:0] coreKey_q, coreKey_d;
    logic [127:0] rspCt_q, rspCt_d;
    logic         grantAny;
    logic         grantId;
    logic         timeoutHit;

    // Both requests pending goes to the rr pointer; a lone request always wins.
    assign grantAny = (state_q == ST_IDLE) && (arb_if.req0 || arb_if.req1);
    assign grantId  = (arb_if.req0 && arb_if.req1) ? rr_q : arb_if.req1;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        jobId_d   = jobId_q;
        corePt_d  = corePt_q;
        coreKey_d = coreKey_q;
        rspCt_d   = rspCt_q;
        case (state_q)
            ST_IDLE: begin
                if (grantAny) begin
                    state_d   = ST_RUN;
                    rr_d      = ~grantId;
                    jobId_d   = grantId;
                    corePt_d  = grantId ? arb_if.pt1  : arb_if.pt0;
                    coreKey_d = grantId ? arb_if.key1 : arb_if.key0;
                end
            end
            ST_RUN: begin
                if (arb_if.core_done) begin
                    rspCt_d = arb_if.core_ct;
                    state_d = ST_GAP;
                end else if (timeoutHit) begin
                    rspCt_d = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_RESP;
            end
            default: begin
                if (arb_if.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            rr_q      <= 1'b0;
            jobId_q   <= 1'b0;
            corePt_q  <= '0;
            coreKey_q <= '0;
            rspCt_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            jobId_q   <= jobId_d;
            corePt_q  <= corePt_d;
            coreKey_q <= coreKey_d;
            rspCt_q   <= rspCt_d;
        end
    end

`ifdef AES_ARB_TIMEOUT_EN
    localparam logic [7:0] RUN_LIMIT = 8'(TIMEOUT_CYC - 1);

    logic [7:0] runCnt_q, runCnt_d;
    logic       rspErr_q, rspErr_d;

    // The counter rests at zero outside RUN, so every job starts counting fresh.
    assign timeoutHit = (state_q == ST_RUN) && (runCnt_q == RUN_LIMIT);

    always_comb begin
        runCnt_d = '0;
        rspErr_d = rspErr_q;
        if (state_q == ST_RUN) begin
            runCnt_d = runCnt_q + 8'd1;
            if (arb_if.core_done) begin
                rspErr_d = 1'b0;
            end else if (timeoutHit) begin
                rspErr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            runCnt_q <= '0;
            rspErr_q <= 1'b0;
        end else begin
            runCnt_q <= runCnt_d;
            rspErr_q <= rspErr_d;
        end
    end

    assign arb_if.rsp_err = rspErr_q;
`else
    assign timeoutHit     = 1'b0;
    assign arb_if.rsp_err = 1'b0;
`endif

    // Grants are gated by rstn so a request held through reset is not acknowledged.
    assign arb_if.gnt0       = rstn && grantAny && !grantId;
    assign arb_if.gnt1       = rstn && grantAny && grantId;
    assign arb_if.core_start = (state_q == ST_RUN);
    assign arb_if.core_pt    = corePt_q;
    assign arb_if.core_key   = coreKey_q;
    assign arb_if.rsp_valid  = (state_q == ST_RESP);
    assign arb_if.rsp_id     = jobId_q;
    assign arb_if.rsp_ct     = rspCt_q;
    assign arb_if.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Self-checking bench for aes_job_arbiter: a timeline model of each job plus
// directed scenarios with hand-computed literals.
module tb_aes_job_arbiter;

    localparam int TIMEOUT = 15;
    localparam int CORE_CYC = 12;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ALT_PT   = 128'h11111111111111111111111111111111;
    localparam logic [127:0] ALT_KEY  = 128'h22222222222222222222222222222222;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;
    int   cycleNo = 0;

    aes_job_arbiter_if bus();

    aes_job_arbiter #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .arb_if (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNo++;

    // Core stand-in: finishes CORE_CYC cycles into RUN; FIPS-197 vector or pt^key otherwise.
    int           runCnt = 0;
    bit           coreEnable = 1'b1;
    logic         strayDone = 1'b0;
    logic         modelDone = 1'b0;
    logic [127:0] modelCt = '0;

    always @(posedge clk) begin
        #1;
        if (bus.core_start) runCnt++;
        else runCnt = 0;
        modelDone = coreEnable && bus.core_start && (runCnt == CORE_CYC);
        modelCt = (bus.core_pt == FIPS_PT && bus.core_key == FIPS_KEY) ? FIPS_CT
                                                                      : (bus.core_pt ^ bus.core_key);
    end

    assign bus.core_done = modelDone | strayDone;
    assign bus.core_ct   = modelCt;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Job timeline model: cycles counted from the grant, completion recorded when seen.
    bit           mOpen = 1'b0;
    int           mSince = 0;
    int           mDoneAt = -1;
    bit           mRr = 1'b0;
    bit           mId = 1'b0;
    bit           mErr = 1'b0;
    logic [127:0] mPt = '0;
    logic [127:0] mKey = '0;
    logic [127:0] mCt = '0;
    bit           gntSeen0 = 1'b0;
    bit           gntSeen1 = 1'b0;

    always @(negedge clk) begin : cmp
        logic eBusy, eStart, eValid, eG0, eG1, pick;
        pick = 1'b0;
        if (!rstn) begin
            mOpen = 1'b0; mRr = 1'b0; mId = 1'b0; mErr = 1'b0;
            mPt = '0; mKey = '0; mCt = '0;
            eBusy = 1'b0; eStart = 1'b0; eValid = 1'b0; eG0 = 1'b0; eG1 = 1'b0;
        end else if (!mOpen) begin
            eBusy = 1'b0; eStart = 1'b0; eValid = 1'b0;
            pick = (bus.req0 && bus.req1) ? mRr : bus.req1;
            eG0 = (bus.req0 || bus.req1) && !pick;
            eG1 = (bus.req0 || bus.req1) && pick;
        end else begin
            eG0 = 1'b0; eG1 = 1'b0; eBusy = 1'b1;
            eStart = (mDoneAt < 0);
            eValid = (mDoneAt >= 0) && (mSince >= mDoneAt + 2);
        end
        checkOutput("busy", bus.busy, eBusy);
        checkOutput("core_start", bus.core_start, eStart);
        checkOutput("rsp_valid", bus.rsp_valid, eValid);
        checkOutput("gnt0", bus.gnt0, eG0);
        checkOutput("gnt1", bus.gnt1, eG1);
        checkOutput("core_pt", bus.core_pt, mPt);
        checkOutput("core_key", bus.core_key, mKey);
        if (eValid) begin
            checkOutput("rsp_id", bus.rsp_id, mId);
            checkOutput("rsp_ct", bus.rsp_ct, mCt);
            checkOutput("rsp_err", bus.rsp_err, mErr);
        end
        if (bus.gnt0) gntSeen0 = 1'b1;
        if (bus.gnt1) gntSeen1 = 1'b1;
        if (rstn) begin
            if (!mOpen) begin
                if (eG0 || eG1) begin
                    mOpen = 1'b1; mSince = 1; mDoneAt = -1;
                    mId = pick; mRr = !pick;
                    mPt = pick ? bus.pt1 : bus.pt0;
                    mKey = pick ? bus.key1 : bus.key0;
                end
            end else begin
                if (eStart && bus.core_done) begin
                    mDoneAt = mSince; mCt = bus.core_ct; mErr = 1'b0;
                end
`ifdef AES_ARB_TIMEOUT_EN
                else if (eStart && mSince == TIMEOUT) begin
                    mDoneAt = mSince; mCt = '0; mErr = 1'b1;
                end
`endif
                if (eValid && bus.rsp_ready) mOpen = 1'b0;
                mSince++;
            end
        end
    end

    // Requesters drop their request just after the edge that consumed the grant.
    task automatic tick();
        @(posedge clk);
        #1;
        if (gntSeen0) begin bus.req0 = 1'b0; gntSeen0 = 1'b0; end
        if (gntSeen1) begin bus.req1 = 1'b0; gntSeen1 = 1'b0; end
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic rdy);
        bus.req0 = r0;
        bus.req1 = r1;
        bus.rsp_ready = rdy;
    endtask

    task automatic waitValid(input int maxCyc);
        int n = 0;
        while (!bus.rsp_valid && n < maxCyc) begin
            tick();
            n++;
        end
        checkOutput("wait_rsp_valid", bus.rsp_valid, 1'b1);
    endtask

    task automatic applyReset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  gCyc;
        int  cnt;
        bit  sawValid;
        rstn = 1'b0;
        bus.pt0 = FIPS_PT;  bus.key0 = FIPS_KEY;
        bus.pt1 = ALT_PT;   bus.key1 = ALT_KEY;
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("rst_busy", bus.busy, 1'b0);
        checkOutput("rst_gnt0", bus.gnt0, 1'b0);
        checkOutput("rst_core_start", bus.core_start, 1'b0);
        checkOutput("rst_rsp_valid", bus.rsp_valid, 1'b0);
        checkOutput("rst_core_pt", bus.core_pt, 128'h0);
        checkOutput("rst_rsp_ct", bus.rsp_ct, 128'h0);
        checkOutput("rst_rsp_id", bus.rsp_id, 1'b0);
        checkOutput("rst_rsp_err", bus.rsp_err, 1'b0);
        rstn = 1'b1;

        // Lone job held through reset is granted on the first live edge.
        @(negedge clk);
        checkOutput("lone_gnt0", bus.gnt0, 1'b1);
        gCyc = cycleNo;
        tick();
        waitValid(40);
        checkOutput("lone_latency", 128'(cycleNo - gCyc), 128'd14);
        checkOutput("lone_rsp_id", bus.rsp_id, 1'b0);
        checkOutput("lone_rsp_ct", bus.rsp_ct, FIPS_CT);
        checkOutput("lone_rsp_err", bus.rsp_err, 1'b0);
        tick();

        // Contention straight after reset: requester 0 first, then requester 1.
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("cont_gnt0", bus.gnt0, 1'b1);
        checkOutput("cont_gnt1_wait", bus.gnt1, 1'b0);
        tick();
        waitValid(40);
        checkOutput("cont_first_id", bus.rsp_id, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("cont_gnt1", bus.gnt1, 1'b1);
        tick();
        waitValid(40);
        checkOutput("cont_second_id", bus.rsp_id, 1'b1);
        checkOutput("cont_second_ct", bus.rsp_ct, 128'h33333333333333333333333333333333);
        tick();

        // Backpressure with requester 1 waiting behind a held response.
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp_gnt0", bus.gnt0, 1'b1);
        tick();
        bus.req1 = 1'b1;
        waitValid(40);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_valid_held", bus.rsp_valid, 1'b1);
            checkOutput("bp_ct_held", bus.rsp_ct, FIPS_CT);
            checkOutput("bp_no_gnt1", bus.gnt1, 1'b0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_accept_no_gnt", bus.gnt1, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("bp_gnt1_after", bus.gnt1, 1'b1);
        tick();
        waitValid(40);
        tick();

        // Stray completion flag while idle.
        applyStimulus(1'b0, 1'b0, 1'b1);
        strayDone = 1'b1;
        @(negedge clk);
        checkOutput("stray_busy", bus.busy, 1'b0);
        tick();
        strayDone = 1'b0;
        @(negedge clk);
        checkOutput("stray_busy_after", bus.busy, 1'b0);
        checkOutput("stray_valid_after", bus.rsp_valid, 1'b0);
        tick();

        // Reset pulsed in RUN cycle 5 abandons the job.
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("mid_gnt0", bus.gnt0, 1'b1);
        tick();
        repeat (4) tick();
        checkOutput("mid_in_run", bus.core_start, 1'b1);
        #1 rstn = 1'b0;
        #1;
        checkOutput("mid_core_start_drop", bus.core_start, 1'b0);
        checkOutput("mid_busy_drop", bus.busy, 1'b0);
        tick();
        rstn = 1'b1;
        sawValid = 1'b0;
        repeat (20) begin
            tick();
            if (bus.rsp_valid) sawValid = 1'b1;
        end
        checkOutput("mid_no_rsp", sawValid, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("mid_next_gnt1", bus.gnt1, 1'b1);
        tick();
        waitValid(40);
        checkOutput("mid_next_id", bus.rsp_id, 1'b1);
        tick();

`ifdef AES_ARB_TIMEOUT_EN
        // Core never completes: watchdog ends RUN after TIMEOUT cycles.
        coreEnable = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("to_gnt0", bus.gnt0, 1'b1);
        tick();
        cnt = 0;
        while (bus.core_start && cnt < 300) begin
            cnt++;
            tick();
        end
        checkOutput("to_run_cycles", 128'(cnt), 128'd15);
        waitValid(10);
        checkOutput("to_rsp_err", bus.rsp_err, 1'b1);
        checkOutput("to_rsp_ct", bus.rsp_ct, 128'h0);
        coreEnable = 1'b1;
        tick();
`else
        cnt = 0;
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
